// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: forwarding selects, hazard FSM states,
// bubble control encoding and the forwarding compare helper.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MWAIT   = 2'd2
  } state_t;

  // Control bits carried by the ID/EX and later pipeline registers.
  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic jump;
  } pipe_ctl_t;

  // A bubble is an instruction with every control bit cleared.
  localparam pipe_ctl_t CTRL_NOP = '0;

  // Operand source for one ALU input; MEM is newer than WB, x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic       mem_we,
                                         input logic [4:0] mem_rd,
                                         input logic       wb_we,
                                         input logic [4:0] wb_rd,
                                         input logic [4:0] rs);
    logic [1:0] sel;
    sel = FWD_RF;
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the hazard controller and the pipeline it sequences.
// The master side is the controller: it observes stage indices/control bits
// and owns every stage enable, flush, forwarding select and counter.
// Data-memory handshake: dmem_req marks an outstanding MEM-stage access;
// the access completes in the cycle dmem_ready is 1. While dmem_req is 1 and
// dmem_ready is 0 the whole pipeline holds.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  import pipe_ctrl_pkg::*;

  logic [4:0]       id_rs1, id_rs2;
  logic             id_uses_rs1, id_uses_rs2;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic             ex_regwrite, ex_memread;
  logic [4:0]       mem_rd;
  logic             mem_regwrite;
  logic [4:0]       wb_rd;
  logic             wb_regwrite;
  logic             branch_taken;
  logic             dmem_req, dmem_ready;

  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  state_t           state_dbg;

  modport master (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
    input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    input  branch_taken, dmem_req, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, fwd_a, fwd_b,
    output mem_timeout, stall_cnt, flush_cnt, state_dbg
  );

  modport slave (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread,
    output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    output branch_taken, dmem_req, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, fwd_a, fwd_b,
    input  mem_timeout, stall_cnt, flush_cnt, state_dbg
  );
endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Purely combinational ALU operand forwarding for both EX-stage sources.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic       mem_regwrite,
  input  logic [4:0] mem_rd,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_rd,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  // Same priority compare applied independently to each operand.
  always_comb begin
    fwd_a = fwd_sel(mem_regwrite, mem_rd, wb_regwrite, wb_rd, ex_rs1);
    fwd_b = fwd_sel(mem_regwrite, mem_rd, wb_regwrite, wb_rd, ex_rs2);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes,
// data-memory wait freezes, operand forwarding and performance counters.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.master bus
);

  localparam int              WC_W   = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(WAIT_TIMEOUT);

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             at_to_q, mem_timeout_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_inc, flush_inc;
  logic             fz, lu_raw, lu;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush;
  logic [1:0]       fwd_a_raw, fwd_b_raw;
  logic             unused_ex_regwrite;

  // Load-use is detected from the load's destination alone; ex_regwrite is redundant.
  assign unused_ex_regwrite = bus.ex_regwrite;

  assign fz     = bus.dmem_req && !bus.dmem_ready;
  assign lu_raw = bus.ex_memread && (bus.ex_rd != 5'd0) &&
                  ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                   (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));
  // The stalled instruction sees the same load again once; that must not re-stall.
  assign lu     = lu_raw && (state_q != ST_LDSTALL);

  fwd_unit u_fwd (
    .mem_regwrite (bus.mem_regwrite),
    .mem_rd       (bus.mem_rd),
    .wb_regwrite  (bus.wb_regwrite),
    .wb_rd        (bus.wb_rd),
    .ex_rs1       (bus.ex_rs1),
    .ex_rs2       (bus.ex_rs2),
    .fwd_a        (fwd_a_raw),
    .fwd_b        (fwd_b_raw)
  );

  // Next state and stage controls, priority freeze > branch > load-use.
  always_comb begin
    state_d    = ST_RUN;
    wait_cnt_d = '0;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    if (reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (fz) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      state_d  = ST_MWAIT;
      if (state_q == ST_MWAIT) begin
        wait_cnt_d = (wait_cnt_q == WC_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
      end
    end else if (bus.branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_inc  = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      stall_inc  = 1'b1;
      state_d    = ST_LDSTALL;
    end
  end

  // State, wait counter, timeout pulse and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      at_to_q       <= 1'b0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      // Rising edge of "counter saturated", delayed one cycle.
      at_to_q       <= (wait_cnt_q == WC_MAX);
      mem_timeout_q <= (wait_cnt_q == WC_MAX) && !at_to_q;
      if (stall_inc) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.fwd_a       = reset ? FWD_RF : fwd_a_raw;
  assign bus.fwd_b       = reset ? FWD_RF : fwd_b_raw;
  assign bus.mem_timeout = mem_timeout_q && !reset;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with an expected-output queue.
module tb_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  hazard_ctrl_if #(.CNT_W(32)) bus ();

  hazard_ctrl #(.WAIT_TIMEOUT(16), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Expected control word {enables[4:0], ifid_flush, idex_flush, fwd_a, fwd_b, mem_timeout}.
  function automatic logic [11:0] ex(input logic [4:0] en, input logic [1:0] fl,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic to);
    return {en, fl, fa, fb, to};
  endfunction

  function automatic logic [11:0] observed();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.fwd_a, bus.fwd_b, bus.mem_timeout};
  endfunction

  localparam logic [4:0] EN_ALL = 5'b11111;
  localparam logic [4:0] EN_STL = 5'b00111;
  localparam logic [4:0] EN_NON = 5'b00000;

  // Driver helpers.
  task automatic idle_inputs();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.ex_rs1 = 5'd0; bus.ex_rs2 = 5'd0; bus.ex_rd = 5'd0;
    bus.ex_regwrite = 1'b0; bus.ex_memread = 1'b0;
    bus.mem_rd = 5'd0; bus.mem_regwrite = 1'b0;
    bus.wb_rd = 5'd0; bus.wb_regwrite = 1'b0;
    bus.branch_taken = 1'b0;
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  task automatic drive_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2);
    bus.ex_memread = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = rd;
    bus.id_rs1 = rs1; bus.id_uses_rs1 = u1;
    bus.id_rs2 = rs2; bus.id_uses_rs2 = u2;
  endtask

  // Scoreboard: pop the oldest expectation and compare against the DUT.
  task automatic sb_check();
    logic [11:0] e;
    string       t;
    logic [11:0] o;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = observed();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", t, o, e);
    end
  endtask

  // One cycle: record expectation for the inputs just driven, check mid-cycle, advance.
  task automatic step(input logic [11:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_val(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic chk_state(input string tag, input state_t e);
    checks++;
    assert (bus.state_dbg === e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, bus.state_dbg, e);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    // Forwarding condition present during reset must be masked.
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd3; bus.ex_rs1 = 5'd3;

    step(ex(EN_NON, 2'b11, FWD_RF, FWD_RF, 1'b0), "reset_outputs");
    chk_val("reset_stall_cnt", bus.stall_cnt, 0);
    chk_val("reset_flush_cnt", bus.flush_cnt, 0);
    chk_state("reset_state", ST_RUN);
    reset = 1'b0;
    idle_inputs();
    step(ex(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0), "idle_run");

    // LW x5 then add x6,x5,x1: one bubble, then the held hazard is ignored.
    drive_load_use(5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
    step(ex(EN_STL, 2'b01, FWD_RF, FWD_RF, 1'b0), "lu_rs1_stall");
    chk_state("lu_state_ldstall", ST_LDSTALL);
    chk_val("lu_stall_cnt", bus.stall_cnt, 1);
    step(ex(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0), "lu_second_cycle_normal");
    chk_state("lu_back_to_run", ST_RUN);
    idle_inputs();

    // Load into x0 never stalls.
    drive_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    step(ex(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0), "lu_x0_no_stall");
    // Matching index but source not read.
    drive_load_use(5'd9, 5'd9, 1'b0, 5'd2, 1'b1);
    step(ex(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0), "lu_unused_src_no_stall");
    // Hazard through rs2 only.
    drive_load_use(5'd7, 5'd1, 1'b1, 5'd7, 1'b1);
    step(ex(EN_STL, 2'b01, FWD_RF, FWD_RF, 1'b0), "lu_rs2_stall");
    idle_inputs();
    step(ex(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0), "after_rs2_stall");
    chk_val("stall_cnt_two", bus.stall_cnt, 2);

    // Forwarding: MEM beats WB, WB alone, x0 excluded, operand b.
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd3;
    bus.wb_regwrite  = 1'b1; bus.wb_rd  = 5'd3;
    bus.ex_rs1 = 5'd3; bus.ex_rs2 = 5'd4;
    step(ex(EN_ALL, 2'b00, FWD_MEM, FWD_RF, 1'b0), "fwd_a_mem_over_wb");
    bus.mem_regwrite = 1'b0;
    step(ex(EN_ALL, 2'b00, FWD_WB, FWD_RF, 1'b0), "fwd_a_wb");
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd0; bus.ex_rs1 = 5'd0;
    bus.wb_rd = 5'd4;
    step(ex(EN_ALL, 2'b00, FWD_RF, FWD_WB, 1'b0), "fwd_x0_and_b_wb");
    bus.mem_rd = 5'd4;
    step(ex(EN_ALL, 2'b00, FWD_RF, FWD_MEM, 1'b0), "fwd_b_mem");
    idle_inputs();

    // Taken branch in RUN.
    bus.branch_taken = 1'b1;
    step(ex(EN_ALL, 2'b11, FWD_RF, FWD_RF, 1'b0), "branch_flush");
    chk_val("flush_cnt_one", bus.flush_cnt, 1);
    // Branch outranks a simultaneous load-use.
    drive_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    step(ex(EN_ALL, 2'b11, FWD_RF, FWD_RF, 1'b0), "branch_over_lu");
    chk_val("flush_cnt_two", bus.flush_cnt, 2);
    chk_val("stall_cnt_unchanged", bus.stall_cnt, 2);
    idle_inputs();
    step(ex(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0), "idle_after_branch");

    // Freeze with branch held: applied only on the release cycle.
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0; bus.branch_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(ex(EN_NON, 2'b00, FWD_RF, FWD_RF, 1'b0), "freeze_branch_held");
      chk_state("freeze_state", ST_MWAIT);
    end
    chk_val("flush_cnt_during_freeze", bus.flush_cnt, 2);
    bus.dmem_ready = 1'b1;
    step(ex(EN_ALL, 2'b11, FWD_RF, FWD_RF, 1'b0), "freeze_release_branch");
    chk_val("flush_cnt_release", bus.flush_cnt, 3);
    chk_state("release_state", ST_RUN);
    idle_inputs();
    step(ex(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0), "after_release");
    chk_val("flush_cnt_no_repeat", bus.flush_cnt, 3);

    // Release cycle evaluates load-use normally.
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    step(ex(EN_NON, 2'b00, FWD_RF, FWD_RF, 1'b0), "freeze_before_lu");
    bus.dmem_ready = 1'b1;
    drive_load_use(5'd8, 5'd8, 1'b1, 5'd0, 1'b0);
    step(ex(EN_STL, 2'b01, FWD_RF, FWD_RF, 1'b0), "release_lu_stall");
    chk_val("stall_cnt_three", bus.stall_cnt, 3);
    idle_inputs();
    step(ex(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0), "after_release_lu");

    // Long wait: one timeout pulse two cycles after the counter saturates.
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(ex(EN_NON, 2'b00, FWD_RF, FWD_RF, (k == 18)), "timeout_freeze");
    end
    bus.dmem_ready = 1'b1;
    step(ex(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0), "timeout_release");
    chk_state("timeout_release_state", ST_RUN);
    idle_inputs();

    // Reset in the middle of a freeze with a branch held.
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0; bus.branch_taken = 1'b1;
    step(ex(EN_NON, 2'b00, FWD_RF, FWD_RF, 1'b0), "pre_reset_freeze1");
    step(ex(EN_NON, 2'b00, FWD_RF, FWD_RF, 1'b0), "pre_reset_freeze2");
    reset = 1'b1;
    step(ex(EN_NON, 2'b11, FWD_RF, FWD_RF, 1'b0), "reset_mid_freeze");
    chk_val("rst2_stall_cnt", bus.stall_cnt, 0);
    chk_val("rst2_flush_cnt", bus.flush_cnt, 0);
    chk_state("rst2_state", ST_RUN);
    reset = 1'b0;
    idle_inputs();
    step(ex(EN_ALL, 2'b00, FWD_RF, FWD_RF, 1'b0), "post_reset_run");
    chk_val("post_reset_flush_cnt", bus.flush_cnt, 0);
    chk_state("post_reset_state", ST_RUN);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
